setup_input_server: RTL
=======================

Name: setup_input_server

Overview:
- Host-side responder directly upstream of the Setup stage; replaces the bench-only input feeder with synthesizable logic.
- Loaded with the program inputs over a simple valid/ready stream, then answers Setup's requests:
  - In St_Header it returns the input count.
  - In St_InputEncryption it returns the indexed input word.
- Raises Done when Setup reaches St_Execute.

Parameters:
- DataWidth, 128, width of Setup DataIn/DataOut and of each input word.
- MaxInputLength, 16, input buffer depth (words).
- SetupStatesWidth, 3, width of Setup Cmd; must match the shared FSM header.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- LoadData  in  DataWidth  input word from the host.
- LoadValid  in  1  LoadData valid.
- LoadLast  in  1  marks the final word of the load; qualified by LoadValid.
- LoadReady  out  1  buffer accepts a word this cycle.
- Cmd  in  SetupStatesWidth  Setup's current state.
- ReqData  in  DataWidth  Setup DataOut: the input index in St_InputEncryption.
- ReqValid  in  1  Setup DataOutValid; one request per high cycle.
- RespData  out  DataWidth  drives Setup DataIn.
- RespValid  out  1  drives Setup DataInValid.
- InputCount  out  $clog2(MaxInputLength+1)  number of words loaded.
- Done  out  1  Setup reached St_Execute; sticky.
- Error  out  1  sticky fault flag.

Behaviour:
- Reset (async assert, sync release):
  - State S_LOAD; LoadReady=1; RespData=0; RespValid=0; InputCount=0; Done=0; Error=0.
  - Buffer contents are don't-care.
- S_LOAD:
  - A word is accepted when LoadValid & LoadReady. It is written to buf[InputCount], and InputCount increments.
  - Accept with LoadLast=1 → S_SERVE next cycle.
  - Accept making InputCount==MaxInputLength → S_SERVE even without LoadLast.
  - LoadReady is 1 only in S_LOAD.
  - ReqValid in S_LOAD is ignored: no response, no error.
- S_SERVE:
  - Every response is registered with 1-cycle latency: a request at edge N gives RespValid=1 for exactly one cycle after edge N+1.
  - Back-to-back requests are allowed; one response per request, in order.
  - ReqValid & Cmd==St_Header → RespData = zero-extended InputCount.
  - ReqValid & Cmd==St_InputEncryption → the full ReqData is compared against InputCount.
    - ReqData < InputCount → RespData = buf[ReqData].
    - Otherwise (including any nonzero upper bits) → RespData=0, RespValid=1, Error=1, state S_ERROR.
  - ReqValid with any other Cmd → ignored.
  - Cmd==St_Execute (ReqValid irrelevant) → Done=1 and state S_DONE next cycle. If ReqValid is also high that cycle, St_Execute wins and no response is produced.
  - RespData holds its last value when RespValid=0.
- S_DONE and S_ERROR:
  - Terminal states. All requests are ignored and LoadReady=0.
  - Only Reset exits.
  - S_ERROR keeps Done=0, even if Cmd later becomes St_Execute.
- Zero-length load: a single LoadValid&LoadLast word is stored, so InputCount=1. There is no way to load zero words; Setup reading the header therefore always sees ≥1.
- Reset mid-operation: any pending response is dropped, RespValid falls immediately (async), and loading restarts at index 0.

Decomposition:
- St_Header, St_InputEncryption, St_Execute and SetupStatesWidth come from the shared FSM header and are not redefined here.
- Server state encodings (S_LOAD, S_SERVE, S_DONE, S_ERROR, 2 bits) go in a new shared header, InputServer.vh, so benches can probe the state.
- One sub-module, setup_input_buffer:
  - MaxInputLength x DataWidth register file.
  - One synchronous write port; one read port with registered output.
  - It supplies the 1-cycle response latency.

Test Plan:
- Basic load and serve:
  - Stimulus: load {0x00112233_44556677_8899aabb_ccddeeff, 0x1, 19(last)}, then drive a St_Header request.
  - Response: InputCount=3, LoadReady drops, and 1 cycle later RespValid=1 with RespData=3.
- Back-to-back reads:
  - Stimulus: St_InputEncryption requests with ReqData=2, 0, 1 on consecutive cycles.
  - Response: RespValid high 3 consecutive cycles; RespData = 19, 0x00112233…eeff, 0x1 in that order.
- Out-of-range index:
  - Stimulus: ReqData=3 with InputCount=3; separately, ReqData=2^64+1.
  - Response: RespData=0 with a RespValid pulse, Error=1 sticky, and a later valid request gets no response.
- Auto-close on full buffer:
  - Stimulus: stream 16 words with LoadLast=0, then hold LoadValid high.
  - Response: InputCount=16, S_SERVE entered, LoadReady=0, the 17th word is not accepted, and the header returns 16.
- Execute, including the simultaneous case:
  - Stimulus: Cmd=St_Execute in the same cycle as ReqValid.
  - Response: Done=1 next cycle, no RespValid, and later requests are ignored.
- Reset mid-serve:
  - Stimulus: assert Reset low while a response is pending.
  - Response: RespValid=0 immediately, InputCount=0, Done=0, Error=0, LoadReady=1; a reload of {7(last)} then answers the header with 1.

Source files
------------

// File: rtl/setup_input_server_pkg.sv
// rtl/setup_input_server_pkg.sv - shared Setup FSM commands and input server state encodings
package setup_input_server_pkg;

    // Setup FSM command encoding shared with the Setup stage
    localparam int SetupStatesWidth = 3;

    localparam logic [SetupStatesWidth-1:0] St_Idle            = 3'd0;
    localparam logic [SetupStatesWidth-1:0] St_Header          = 3'd1;
    localparam logic [SetupStatesWidth-1:0] St_InputEncryption = 3'd2;
    localparam logic [SetupStatesWidth-1:0] St_Execute         = 3'd3;

    // Server states, exposed so benches can probe the controller
    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SERVE = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } server_state_e;

    // Source selected for the registered response word
    typedef enum logic [1:0] {
        RESP_ZERO   = 2'd0,
        RESP_COUNT  = 2'd1,
        RESP_BUFFER = 2'd2
    } resp_src_e;

endpackage

// File: rtl/setup_input_buffer.sv
// rtl/setup_input_buffer.sv - input word register file with registered read port
module setup_input_buffer #(
    parameter int DataWidth = 128,
    parameter int Depth     = 16,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic                 rd_en_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    output logic [DataWidth-1:0] rd_data_o
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rd_data_q;

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register: provides the one-cycle response latency and holds between reads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/setup_input_server.sv
// rtl/setup_input_server.sv - loads program inputs and answers Setup header/input requests
module setup_input_server
    import setup_input_server_pkg::*;
#(
    parameter int DataWidth      = 128,
    parameter int MaxInputLength = 16,
    parameter int CountWidth     = $clog2(MaxInputLength + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [DataWidth-1:0]        load_data_i,
    input  logic                        load_valid_i,
    input  logic                        load_last_i,
    output logic                        load_ready_o,
    input  logic [SetupStatesWidth-1:0] cmd_i,
    input  logic [DataWidth-1:0]        req_data_i,
    input  logic                        req_valid_i,
    output logic [DataWidth-1:0]        resp_data_o,
    output logic                        resp_valid_o,
    output logic [CountWidth-1:0]       input_count_o,
    output logic                        done_o,
    output logic                        error_o
);

    localparam int AddrWidth = $clog2(MaxInputLength);

    server_state_e         state_q, state_d;
    logic [CountWidth-1:0] count_q, count_d;
    resp_src_e             resp_src_q, resp_src_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  buf_wr_en;
    logic                  buf_rd_en;
    logic [DataWidth-1:0]  buf_rd_data;
    logic                  req_in_range;

    // Full-width compare so any nonzero upper index bits count as out of range
    assign req_in_range = req_data_i < DataWidth'(count_q);

    setup_input_buffer #(
        .DataWidth (DataWidth),
        .Depth     (MaxInputLength),
        .AddrWidth (AddrWidth)
    ) u_buffer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (buf_wr_en),
        .wr_addr_i (count_q[AddrWidth-1:0]),
        .wr_data_i (load_data_i),
        .rd_en_i   (buf_rd_en),
        .rd_addr_i (req_data_i[AddrWidth-1:0]),
        .rd_data_o (buf_rd_data)
    );

    // Controller state and response bookkeeping registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_LOAD;
            count_q      <= '0;
            resp_src_q   <= RESP_ZERO;
            resp_valid_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            resp_src_q   <= resp_src_d;
            resp_valid_q <= resp_valid_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state: load until last/full, then serve requests until Execute or a bad index
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        resp_src_d   = resp_src_q;
        resp_valid_d = 1'b0;
        done_d       = done_q;
        error_d      = error_q;
        buf_wr_en    = 1'b0;
        buf_rd_en    = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (load_valid_i) begin
                    buf_wr_en = 1'b1;
                    count_d   = count_q + 1'b1;
                    if (load_last_i || (count_q == CountWidth'(MaxInputLength - 1))) begin
                        state_d = S_SERVE;
                    end
                end
            end
            S_SERVE: begin
                if (cmd_i == St_Execute) begin
                    // Execute takes priority over a coincident request
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (req_valid_i) begin
                    if (cmd_i == St_Header) begin
                        resp_valid_d = 1'b1;
                        resp_src_d   = RESP_COUNT;
                    end else if (cmd_i == St_InputEncryption) begin
                        resp_valid_d = 1'b1;
                        if (req_in_range) begin
                            resp_src_d = RESP_BUFFER;
                            buf_rd_en  = 1'b1;
                        end else begin
                            resp_src_d = RESP_ZERO;
                            error_d    = 1'b1;
                            state_d    = S_ERROR;
                        end
                    end
                end
            end
            default: begin
                // S_DONE and S_ERROR are terminal; only reset leaves them
            end
        endcase
    end

    // Response word is selected from registered sources, so it holds while idle
    always_comb begin
        resp_data_o = '0;
        case (resp_src_q)
            RESP_COUNT:  resp_data_o = DataWidth'(count_q);
            RESP_BUFFER: resp_data_o = buf_rd_data;
            default:     resp_data_o = '0;
        endcase
    end

    assign load_ready_o  = (state_q == S_LOAD);
    assign resp_valid_o  = resp_valid_q;
    assign input_count_o = count_q;
    assign done_o        = done_q;
    assign error_o       = error_q;

endmodule
